bht_update_controller: RTL

Sequences all writes into the 256-entry 2-bit branch history table (BHT) RAM through its single read/write maintenance port. The decode-stage lookup port is separate and not controlled here.
- After reset, and on every flush, it sweeps the whole table to a known value.
- In between, it queues resolved-branch updates from the MEM stage and applies each one as a read-modify-write of the 2-bit saturating counter.

---
 rtl/bht_update_controller_if.sv | 26 ++
 rtl/bht_update_controller.sv | 128 ++++++++++++
 2 files changed

// File: rtl/bht_update_controller_if.sv
// Update-request and BHT maintenance-port bundle shared by the update controller and its environment.
// The slave modport is the controller's view; the master modport is the MEM stage plus RAM side.
interface bht_update_controller_if #(
    parameter int INDEX_W = 8
);
    logic               upd_valid;
    logic               upd_ready;
    logic [INDEX_W-1:0] upd_index;
    logic               upd_taken;

    logic [INDEX_W-1:0] mem_addr;
    logic               mem_re;
    logic [1:0]         mem_rdata;
    logic               mem_we;
    logic [1:0]         mem_wdata;

    modport master (
        output upd_valid, upd_index, upd_taken, mem_rdata,
        input  upd_ready, mem_addr, mem_re, mem_we, mem_wdata
    );

    modport slave (
        input  upd_valid, upd_index, upd_taken, mem_rdata,
        output upd_ready, mem_addr, mem_re, mem_we, mem_wdata
    );
endinterface

// File: rtl/bht_update_controller.sv
// Owns every write into the BHT: sweeps the table to INIT_VAL after reset or flush, and
// applies queued resolved-branch updates as read-modify-write of the 2-bit saturating counters.
module bht_update_controller #(
    parameter int         INDEX_W    = 8,
    parameter logic [1:0] INIT_VAL   = 2'b00,
    parameter int         FIFO_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    bht_update_controller_if.slave  bus,
    input  logic                    flush_req,
    output logic                    init_done,
    output logic                    busy
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [INDEX_W-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {
        SWEEP,
        IDLE,
        RD,
        WR
    } state_t;

    state_t             state;
    logic [INDEX_W-1:0] sweep_ctr;

    logic [INDEX_W-1:0] fifo_index [FIFO_DEPTH];
    logic               fifo_taken [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;

    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic [INDEX_W-1:0] head_index;
    logic               head_taken;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [1:0] sat(input logic [1:0] v, input logic taken);
        if (taken)
            return (v == 2'b11) ? v : v + 2'b01;
        else
            return (v == 2'b00) ? v : v - 2'b01;
    endfunction

    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign head_index = fifo_index[rd_ptr];
    assign head_taken = fifo_taken[rd_ptr];

    // Ready uses the pre-pop full flag, so a full queue refuses even while WR frees a slot.
    assign bus.upd_ready = (state != SWEEP) && !fifo_full && !flush_req;
    assign push          = bus.upd_valid && bus.upd_ready;
    assign pop           = (state == WR);
    assign count_next    = count + CNT_W'(push) - CNT_W'(pop);

    assign init_done = (state != SWEEP);
    assign busy      = (state != IDLE);

    // Enables are gated by rst_n so nothing reaches the RAM the moment reset falls.
    always_comb begin
        bus.mem_addr  = head_index;
        bus.mem_re    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = sat(bus.mem_rdata, head_taken);
        case (state)
            SWEEP: begin
                bus.mem_we    = rst_n;
                bus.mem_addr  = sweep_ctr;
                bus.mem_wdata = INIT_VAL;
            end
            RD:      bus.mem_re = rst_n;
            WR:      bus.mem_we = rst_n;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_index[wr_ptr] <= bus.upd_index;
            fifo_taken[wr_ptr] <= bus.upd_taken;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SWEEP;
            sweep_ctr <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else if (flush_req) begin
            state     <= SWEEP;
            sweep_ctr <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            count <= count_next;
            case (state)
                SWEEP: begin
                    sweep_ctr <= sweep_ctr + INDEX_W'(1);
                    if (sweep_ctr == LAST_IDX)
                        state <= IDLE;
                end
                IDLE: begin
                    if (!fifo_empty)
                        state <= RD;
                end
                RD: state <= WR;
                WR: state <= (count_next != '0) ? RD : IDLE;
                default: state <= SWEEP;
            endcase
        end
    end
endmodule
